// File: rtl/router_out_arbiter.sv
// Packet-granular round-robin scheduler draining three router output FIFOs onto one link.
// A grant is held for header, payload and parity; a stalled grant is flushed after a timeout.
module router_out_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 30,
    parameter int TMR_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic [DATA_W-1:0] dout_0,
    input  logic [DATA_W-1:0] dout_1,
    input  logic [DATA_W-1:0] dout_2,
    input  logic              out_ready,
    output logic              read_enb_0,
    output logic              read_enb_1,
    output logic              read_enb_2,
    output logic [DATA_W-1:0] data_out,
    output logic              vld_out,
    output logic              soft_reset_0,
    output logic              soft_reset_1,
    output logic              soft_reset_2,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int CNT_W = DATA_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND_HDR,
        SEND_BODY
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         rr_ptr;
    logic [1:0]         rr_next;
    logic [1:0]         grant_next;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   remaining_next;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_next;
    logic [2:0]         soft_reset;
    logic [2:0]         soft_reset_next;

    logic [2:0]         empty_vec;
    logic               grant_empty;
    logic [DATA_W-1:0]  head_word;
    logic               xfer;
    logic [1:0]         pick;
    logic               pick_valid;
    logic [1:0]         cand_a;
    logic [1:0]         cand_b;
    logic [1:0]         cand_c;

    assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 2'b11;
            rr_ptr     <= 2'd2;
            remaining  <= '0;
            timer      <= '0;
            soft_reset <= '0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            rr_ptr     <= rr_next;
            remaining  <= remaining_next;
            timer      <= timer_next;
            soft_reset <= soft_reset_next;
        end
    end

    // Search order starts just after the last served port so it becomes lowest priority.
    always_comb begin
        case (rr_ptr)
            2'd0:    begin cand_a = 2'd1; cand_b = 2'd2; cand_c = 2'd0; end
            2'd1:    begin cand_a = 2'd2; cand_b = 2'd0; cand_c = 2'd1; end
            default: begin cand_a = 2'd0; cand_b = 2'd1; cand_c = 2'd2; end
        endcase
        pick       = 2'b11;
        pick_valid = 1'b0;
        if (!empty_vec[cand_a]) begin
            pick       = cand_a;
            pick_valid = 1'b1;
        end else if (!empty_vec[cand_b]) begin
            pick       = cand_b;
            pick_valid = 1'b1;
        end else if (!empty_vec[cand_c]) begin
            pick       = cand_c;
            pick_valid = 1'b1;
        end
    end

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        rr_next         = rr_ptr;
        remaining_next  = remaining;
        timer_next      = timer;
        soft_reset_next = '0;
        case (state)
            IDLE: begin
                timer_next = '0;
                if (pick_valid) begin
                    grant_next = pick;
                    state_next = SEND_HDR;
                end
            end
            SEND_HDR, SEND_BODY: begin
                if (xfer) begin
                    timer_next = '0;
                    if (state == SEND_HDR) begin
                        // Header length counts payload only; the extra one covers the parity byte.
                        remaining_next = {1'b0, head_word[DATA_W-1:2]} + CNT_W'(1);
                        state_next     = SEND_BODY;
                    end else begin
                        remaining_next = remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state_next = IDLE;
                            rr_next    = grant;
                            grant_next = 2'b11;
                        end
                    end
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    soft_reset_next[grant] = 1'b1;
                    state_next             = IDLE;
                    rr_next                = grant;
                    grant_next             = 2'b11;
                    timer_next             = '0;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 2'b11;
            end
        endcase
    end

    // Show-ahead FIFOs let the granted head word leave in the same cycle it is popped.
    always_comb begin
        grant_empty = 1'b1;
        head_word   = '0;
        case (grant)
            2'd0:    begin grant_empty = fifo_empty_0; head_word = dout_0; end
            2'd1:    begin grant_empty = fifo_empty_1; head_word = dout_1; end
            2'd2:    begin grant_empty = fifo_empty_2; head_word = dout_2; end
            default: begin grant_empty = 1'b1;         head_word = '0;     end
        endcase
        busy         = (state != IDLE);
        vld_out      = busy && !grant_empty;
        xfer         = vld_out && out_ready;
        read_enb_0   = xfer && (grant == 2'd0);
        read_enb_1   = xfer && (grant == 2'd1);
        read_enb_2   = xfer && (grant == 2'd2);
        data_out     = busy ? head_word : '0;
        soft_reset_0 = soft_reset[0];
        soft_reset_1 = soft_reset[1];
        soft_reset_2 = soft_reset[2];
    end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter with a show-ahead FIFO model on each port.
module tb_router_out_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic [7:0] dout_0, dout_1, dout_2;
    logic       out_ready;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [7:0] data_out;
    logic       vld_out;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic [1:0] grant;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem  [3][256];
    logic [7:0] head [3];
    logic [7:0] tail [3];
    logic       clear_req;
    logic [2:0] pop_vec;
    logic [2:0] flush_vec;

    logic [7:0] pkt1 [5]  = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5C};
    logic [1:0] eg   [17] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd1, 2'd3,
                              2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3};
    logic [7:0] ed   [17] = '{8'h00, 8'h04, 8'h10, 8'h11, 8'h00, 8'h05, 8'h20, 8'h21, 8'h00,
                              8'h06, 8'h30, 8'h31, 8'h00, 8'h07, 8'h12, 8'h13, 8'h00};

    router_out_arbiter #(.DATA_W(8), .TIMEOUT(30), .TMR_W(5)) dut (
        .clock        (clock),
        .reset        (reset),
        .fifo_empty_0 (fifo_empty_0),
        .fifo_empty_1 (fifo_empty_1),
        .fifo_empty_2 (fifo_empty_2),
        .dout_0       (dout_0),
        .dout_1       (dout_1),
        .dout_2       (dout_2),
        .out_ready    (out_ready),
        .read_enb_0   (read_enb_0),
        .read_enb_1   (read_enb_1),
        .read_enb_2   (read_enb_2),
        .data_out     (data_out),
        .vld_out      (vld_out),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2),
        .grant        (grant),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    assign fifo_empty_0 = (head[0] == tail[0]);
    assign fifo_empty_1 = (head[1] == tail[1]);
    assign fifo_empty_2 = (head[2] == tail[2]);
    assign dout_0       = mem[0][head[0]];
    assign dout_1       = mem[1][head[1]];
    assign dout_2       = mem[2][head[2]];
    assign pop_vec      = {read_enb_2, read_enb_1, read_enb_0};
    assign flush_vec    = {soft_reset_2, soft_reset_1, soft_reset_0};

    // Pops and flushes land on the clock edge so the DUT sees pre-edge FIFO state.
    always @(posedge clock) begin
        for (logic [1:0] i = 0; i < 3; i++) begin
            if (clear_req === 1'b1 || flush_vec[i] === 1'b1)
                head[i] <= tail[i];
            else if (pop_vec[i] === 1'b1)
                head[i] <= head[i] + 8'd1;
        end
    end

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [1:0] p, input logic [7:0] b);
        mem[p][tail[p]] = b;
        tail[p] = tail[p] + 8'd1;
    endtask

    // Leaves reset asserted with empty FIFOs, one time unit after a reset edge.
    task automatic do_reset;
        reset     = 1'b1;
        out_ready = 1'b0;
        clear_req = 1'b1;
        next_cycle();
        clear_req = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        push(2'd1, 8'h0D); push(2'd1, 8'hA1); push(2'd1, 8'hA2); push(2'd1, 8'hA3); push(2'd1, 8'h5C);
        out_ready = 1'b1;
        next_cycle();
        checks++; if (grant !== 2'b11) begin errors++; $display("[TB] FAIL reset_grant got %b want 11", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (vld_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld got %b want 0", vld_out); end
        checks++; if (pop_vec !== 3'b000) begin errors++; $display("[TB] FAIL reset_read_enb got %b want 000", pop_vec); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h want 00", data_out); end
        checks++; if (flush_vec !== 3'b000) begin errors++; $display("[TB] FAIL reset_soft got %b want 000", flush_vec); end
    endtask

    task automatic test_single_packet;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy got %b want 0", busy); end
        next_cycle();
        checks++; if (grant !== 2'd1) begin errors++; $display("[TB] FAIL single_grant got %0d want 1", grant); end
        for (logic [2:0] i = 0; i < 5; i++) begin
            checks++; if (vld_out !== 1'b1) begin errors++; $display("[TB] FAIL single_vld[%0d] got %b want 1", i, vld_out); end
            checks++; if (pop_vec !== 3'b010) begin errors++; $display("[TB] FAIL single_read[%0d] got %b want 010", i, pop_vec); end
            checks++; if (data_out !== pkt1[i]) begin errors++; $display("[TB] FAIL single_data[%0d] got %h want %h", i, data_out, pkt1[i]); end
            next_cycle();
        end
        checks++; if (grant !== 2'b11) begin errors++; $display("[TB] FAIL single_end_grant got %b want 11", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_end_busy got %b want 0", busy); end
    endtask

    task automatic test_round_robin;
        do_reset();
        out_ready = 1'b1;
        push(2'd0, 8'h04); push(2'd0, 8'h10); push(2'd0, 8'h11);
        push(2'd0, 8'h07); push(2'd0, 8'h12); push(2'd0, 8'h13);
        push(2'd1, 8'h05); push(2'd1, 8'h20); push(2'd1, 8'h21);
        push(2'd2, 8'h06); push(2'd2, 8'h30); push(2'd2, 8'h31);
        reset = 1'b0;
        #1;
        for (logic [4:0] c = 0; c < 17; c++) begin
            checks++; if (grant !== eg[c]) begin errors++; $display("[TB] FAIL rr_grant[%0d] got %0d want %0d", c, grant, eg[c]); end
            checks++; if (data_out !== ed[c]) begin errors++; $display("[TB] FAIL rr_data[%0d] got %h want %h", c, data_out, ed[c]); end
            next_cycle();
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        out_ready = 1'b1;
        push(2'd2, 8'h10); push(2'd2, 8'h40); push(2'd2, 8'h41);
        push(2'd2, 8'h42); push(2'd2, 8'h43); push(2'd2, 8'h4F);
        reset = 1'b0;
        next_cycle();
        checks++; if (data_out !== 8'h10 || grant !== 2'd2) begin errors++; $display("[TB] FAIL bp_hdr got %h/%0d want 10/2", data_out, grant); end
        next_cycle();
        next_cycle();
        checks++; if (data_out !== 8'h41) begin errors++; $display("[TB] FAIL bp_pre got %h want 41", data_out); end
        next_cycle();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (read_enb_2 !== 1'b0) begin errors++; $display("[TB] FAIL bp_read[%0d] got %b want 0", i, read_enb_2); end
            checks++; if (data_out !== 8'h42 || vld_out !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold[%0d] got %h/%b want 42/1", i, data_out, vld_out); end
            checks++; if (soft_reset_2 !== 1'b0) begin errors++; $display("[TB] FAIL bp_soft[%0d] got %b want 0", i, soft_reset_2); end
            next_cycle();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (read_enb_2 !== 1'b1 || data_out !== 8'h42) begin errors++; $display("[TB] FAIL bp_resume got %b/%h want 1/42", read_enb_2, data_out); end
        next_cycle();
        checks++; if (data_out !== 8'h43) begin errors++; $display("[TB] FAIL bp_next got %h want 43", data_out); end
        next_cycle();
        checks++; if (data_out !== 8'h4F || grant !== 2'd2) begin errors++; $display("[TB] FAIL bp_parity got %h/%0d want 4f/2", data_out, grant); end
        next_cycle();
        checks++; if (grant !== 2'b11 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_end got %b/%b want 11/0", grant, busy); end
    endtask

    task automatic test_timeout;
        do_reset();
        out_ready = 1'b0;
        push(2'd0, 8'h08); push(2'd0, 8'hB0); push(2'd0, 8'hB1); push(2'd0, 8'hB2);
        push(2'd1, 8'h04); push(2'd1, 8'h50); push(2'd1, 8'h51);
        reset = 1'b0;
        next_cycle();
        checks++; if (grant !== 2'd0) begin errors++; $display("[TB] FAIL to_grant got %0d want 0", grant); end
        for (int i = 0; i < 30; i++) begin
            checks++; if (soft_reset_0 !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL to_wait[%0d] got %b/%b want 0/1", i, soft_reset_0, busy); end
            next_cycle();
        end
        checks++; if (soft_reset_0 !== 1'b1) begin errors++; $display("[TB] FAIL to_pulse got %b want 1", soft_reset_0); end
        checks++; if (busy !== 1'b0 || grant !== 2'b11) begin errors++; $display("[TB] FAIL to_idle got %b/%b want 0/11", busy, grant); end
        next_cycle();
        checks++; if (soft_reset_0 !== 1'b0) begin errors++; $display("[TB] FAIL to_pulse_end got %b want 0", soft_reset_0); end
        checks++; if (grant !== 2'd1) begin errors++; $display("[TB] FAIL to_next_grant got %0d want 1", grant); end
        out_ready = 1'b1;
        #1;
        checks++; if (data_out !== 8'h04) begin errors++; $display("[TB] FAIL to_next_hdr got %h want 04", data_out); end
        next_cycle();
        next_cycle();
        next_cycle();
        next_cycle();
        checks++; if (grant !== 2'b11 || busy !== 1'b0) begin errors++; $display("[TB] FAIL to_flushed got %b/%b want 11/0", grant, busy); end
    endtask

    task automatic test_fifo_gap;
        do_reset();
        out_ready = 1'b1;
        push(2'd1, 8'h14); push(2'd1, 8'h60); push(2'd1, 8'h61);
        reset = 1'b0;
        next_cycle();
        checks++; if (grant !== 2'd1 || data_out !== 8'h14) begin errors++; $display("[TB] FAIL gap_hdr got %0d/%h want 1/14", grant, data_out); end
        next_cycle();
        next_cycle();
        checks++; if (data_out !== 8'h61) begin errors++; $display("[TB] FAIL gap_pre got %h want 61", data_out); end
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            checks++; if (vld_out !== 1'b0 || read_enb_1 !== 1'b0) begin errors++; $display("[TB] FAIL gap_vld[%0d] got %b/%b want 0/0", i, vld_out, read_enb_1); end
            checks++; if (busy !== 1'b1 || soft_reset_1 !== 1'b0) begin errors++; $display("[TB] FAIL gap_hold[%0d] got %b/%b want 1/0", i, busy, soft_reset_1); end
        end
        next_cycle();
        push(2'd1, 8'h62); push(2'd1, 8'h63); push(2'd1, 8'h64); push(2'd1, 8'h6F);
        #1;
        checks++; if (vld_out !== 1'b1 || data_out !== 8'h62) begin errors++; $display("[TB] FAIL gap_resume got %b/%h want 1/62", vld_out, data_out); end
        next_cycle();
        next_cycle();
        next_cycle();
        checks++; if (data_out !== 8'h6F || grant !== 2'd1) begin errors++; $display("[TB] FAIL gap_parity got %h/%0d want 6f/1", data_out, grant); end
        next_cycle();
        checks++; if (grant !== 2'b11 || busy !== 1'b0) begin errors++; $display("[TB] FAIL gap_end got %b/%b want 11/0", grant, busy); end
    endtask

    task automatic test_reset_mid_packet;
        do_reset();
        out_ready = 1'b1;
        push(2'd1, 8'h0C); push(2'd1, 8'h90); push(2'd1, 8'h91); push(2'd1, 8'h92); push(2'd1, 8'h9F);
        reset = 1'b0;
        next_cycle();
        next_cycle();
        push(2'd0, 8'h04); push(2'd0, 8'h80); push(2'd0, 8'h81);
        push(2'd2, 8'h04); push(2'd2, 8'hA0); push(2'd2, 8'hA1);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b1 || data_out !== 8'h90) begin errors++; $display("[TB] FAIL mid_body got %b/%h want 1/90", busy, data_out); end
        next_cycle();
        reset = 1'b0;
        #1;
        checks++; if (grant !== 2'b11 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset got %b/%b want 11/0", grant, busy); end
        checks++; if (pop_vec !== 3'b000 || vld_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_read got %b/%b want 000/0", pop_vec, vld_out); end
        next_cycle();
        checks++; if (grant !== 2'd0 || data_out !== 8'h04) begin errors++; $display("[TB] FAIL mid_restart got %0d/%h want 0/04", grant, data_out); end
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        clear_req = 1'b1;
        tail[0]   = 8'd0;
        tail[1]   = 8'd0;
        tail[2]   = 8'd0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_fifo_gap();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
